reg_select_scoreboard: RTL and testbench
========================================

// Module: reg_select_scoreboard
// PURPOSE
//  Parametrised register select/encode unit with a latched IR and a pending-write scoreboard.
//  Decodes Ra/Rb/Rc from its own IR copy and drives registered one-hot r_in/r_out strobes to the register file.
//  Tracks destinations of issued, un-retired instructions and stalls reads of pending registers.
//  Sits between the control sequencer and the register file.
// PARAMETERS
//  NUM_REGS    16  number of GPRs (2..2**REG_W)
//  REG_W        4  register index width
//  IR_W        32  instruction width
//  OPC_LSB     27  LSB of opcode field
//  OPC_W        5  opcode width
//  RA_LSB      23  LSB of Ra field; RB_LSB=19, RC_LSB=15 likewise, each REG_W wide
//  JAL_OPC     20  opcode whose Grb selection is redirected to LINK_REG
//  LINK_REG     8  link register index for JAL
// PORTS
//  clock      in   1         system clock, rising edge
//  reset      in   1         synchronous, active-high reset
//  ir_load    in   1         capture ir_in into internal IR
//  ir_in      in   IR_W      instruction word
//  gra/grb/grc in  1 each    field select; priority gra > grb > grc
//  r_in_req   in   1         request write strobe to selected reg
//  r_out_req  in   1         request read strobe from selected reg
//  ba_out     in   1         base-address read request
//  issue      in   1         mark current IR's Ra (LINK_REG if JAL) pending
//  wb_valid   in   1         writeback retire
//  wb_reg     in   REG_W     register retired
//  r_in       out  NUM_REGS  one-hot write strobe (registered)
//  r_out      out  NUM_REGS  one-hot read strobe (registered)
//  sel_reg    out  REG_W     selected index (combinational, from internal IR)
//  busy       out  NUM_REGS  scoreboard vector
//  stall      out  1         read hazard (combinational)
//  ba_zero    out  1         base address is constant zero (registered)
// BEHAVIOUR
//  - Reset: ir, r_in, r_out, busy, ba_zero = 0. stall follows from busy=0 (0 after reset).
//  - IR: ir <= ir_in when ir_load; else hold. Decode always uses registered ir.
//  - sel_reg: gra->Ra; grb->(opcode==JAL_OPC ? LINK_REG : Rb); grc->Rc; none->0.
//  - sel_valid = (gra|grb|grc) && sel_reg < NUM_REGS. Out-of-range/no select: no strobe.
//  - Latency 1: strobes asserted the cycle after the request, for exactly one cycle per request cycle.
//  - r_in[sel_reg] <= r_in_req && sel_valid. Write is never stalled.
//  - rd = r_out_req | ba_out. stall = rd && sel_valid && busy[sel_reg].
//  - r_out[sel_reg] <= rd && sel_valid && !stall; all other bits 0.
//  - Scoreboard, per bit i each cycle: set if issue && dest==i && dest<NUM_REGS;
//    else clear if wb_valid && wb_reg==i; else hold. Set wins over clear on same reg.
//  - issue with ir_load in the same cycle: issue uses the old ir value.
//  - Retire of a non-busy or out-of-range register: no effect, no error.
//  - stall deasserts the cycle after the retire of the blocking register (busy is registered).
//  - reset mid-operation: all pending bits dropped; next cycle all strobes 0.
// CONFIGURATION
//  REG_SEL_BA_ZERO_EN defined:
//    ba_out with sel_reg==0 gives ba_zero<=1 and r_out all 0 next cycle.
//    R0 is never busy-checked for ba_out. r_out_req on R0 behaves normally.
//  REG_SEL_BA_ZERO_EN undefined:
//    ba_out is identical to r_out_req. ba_zero is tied 0.
// TESTING
//  T1 reset: assert reset 2 cycles -> r_in=r_out=busy=0, stall=0, ba_zero=0.
//  T2 decode: load Ra=3,Rb=5,Rc=7; gra+r_in_req -> r_in=16'h0008 next cycle.
//     grc+r_out_req -> r_out=16'h0080 next cycle.
//  T3 JAL: opcode 20, Rb=2, grb+r_in_req -> r_in=16'h0100 (R8), not 16'h0004.
//  T4 hazard: issue with Ra=4 -> busy=16'h0010.
//     gra+r_out_req -> stall=1, r_out=0.
//     wb_valid,wb_reg=4 -> busy=0 next cycle, then r_out=16'h0010.
//  T5 collision: busy[6]=1, issue Ra=6 and wb_valid wb_reg=6 same cycle -> busy[6] stays 1.
//     Also issue with ir_load same cycle -> old Ra marked.
//  T6 BA: Rb=0, grb+ba_out.
//     With REG_SEL_BA_ZERO_EN -> ba_zero=1, r_out=0.
//     Without the macro -> r_out=16'h0001, ba_zero=0.

Source files
------------

// File: rtl/reg_select_scoreboard_if.sv
// Bundle between the control sequencer (master) and the register select/scoreboard unit (slave).
interface reg_select_scoreboard_if #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned REG_W    = 4,
   parameter int unsigned IR_W     = 32
);
   logic                ir_load;
   logic [IR_W-1:0]     ir_in;
   logic                gra;
   logic                grb;
   logic                grc;
   logic                r_in_req;
   logic                r_out_req;
   logic                ba_out;
   logic                issue;
   logic                wb_valid;
   logic [REG_W-1:0]    wb_reg;
   logic [NUM_REGS-1:0] r_in;
   logic [NUM_REGS-1:0] r_out;
   logic [REG_W-1:0]    sel_reg;
   logic [NUM_REGS-1:0] busy;
   logic                stall;
   logic                ba_zero;

   modport master (
      output ir_load, ir_in, gra, grb, grc, r_in_req, r_out_req, ba_out, issue, wb_valid, wb_reg,
      input  r_in, r_out, sel_reg, busy, stall, ba_zero
   );

   modport slave (
      input  ir_load, ir_in, gra, grb, grc, r_in_req, r_out_req, ba_out, issue, wb_valid, wb_reg,
      output r_in, r_out, sel_reg, busy, stall, ba_zero
   );
endinterface

// File: rtl/reg_select_scoreboard.sv
// Register select/encode unit with a latched IR and a pending-write scoreboard.
// Optional feature REG_SEL_BA_ZERO_EN: base-address read of R0 yields constant-zero flag.
module reg_select_scoreboard #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned REG_W    = 4,
   parameter int unsigned IR_W     = 32,
   parameter int unsigned OPC_LSB  = 27,
   parameter int unsigned OPC_W    = 5,
   parameter int unsigned RA_LSB   = 23,
   parameter int unsigned RB_LSB   = 19,
   parameter int unsigned RC_LSB   = 15,
   parameter int unsigned JAL_OPC  = 20,
   parameter int unsigned LINK_REG = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   reg_select_scoreboard_if.slave bus
);

   logic [IR_W-1:0]     ir_q, ir_d;
   logic [NUM_REGS-1:0] r_in_q, r_in_d;
   logic [NUM_REGS-1:0] r_out_q, r_out_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;

   logic [OPC_W-1:0]    opc;
   logic [REG_W-1:0]    ra, rb, rc, sel_reg, dest;
   logic [NUM_REGS-1:0] sel_oh;
   logic                is_jal, sel_any, sel_valid, rd, stall;
   logic                unused_ir;

   assign opc       = ir_q[OPC_LSB +: OPC_W];
   assign ra        = ir_q[RA_LSB +: REG_W];
   assign rb        = ir_q[RB_LSB +: REG_W];
   assign rc        = ir_q[RC_LSB +: REG_W];
   assign unused_ir = ^ir_q;
   assign is_jal    = (32'(opc) == JAL_OPC);
   assign dest      = is_jal ? REG_W'(LINK_REG) : ra;

   always_comb begin
      sel_reg = '0;
      if (bus.gra)      sel_reg = ra;
      else if (bus.grb) sel_reg = is_jal ? REG_W'(LINK_REG) : rb;
      else if (bus.grc) sel_reg = rc;
   end

   always_comb begin
      sel_oh = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         sel_oh[i] = (32'(sel_reg) == i);
      end
   end

   assign sel_any   = bus.gra | bus.grb | bus.grc;
   assign sel_valid = sel_any && (32'(sel_reg) < NUM_REGS);

`ifdef REG_SEL_BA_ZERO_EN
   logic ba_r0;
   logic ba_zero_q, ba_zero_d;

   // R0 base reads are satisfied by the zero flag, so they neither strobe nor busy-check R0.
   assign ba_r0     = bus.ba_out && sel_any && (sel_reg == '0);
   assign rd        = bus.r_out_req | (bus.ba_out & ~ba_r0);
   assign ba_zero_d = ba_r0;

   always_ff @(posedge clock) begin
      if (reset) ba_zero_q <= 1'b0;
      else       ba_zero_q <= ba_zero_d;
   end

   assign bus.ba_zero = ba_zero_q;
`else
   assign rd          = bus.r_out_req | bus.ba_out;
   assign bus.ba_zero = 1'b0;
`endif

   assign stall = rd && sel_valid && (|(busy_q & sel_oh));

   always_comb begin
      ir_d    = bus.ir_load ? bus.ir_in : ir_q;
      r_in_d  = (bus.r_in_req && sel_valid) ? sel_oh : '0;
      r_out_d = (rd && sel_valid && !stall) ? sel_oh : '0;
   end

   // Issue uses the pre-load IR, and a set beats a retire on the same register.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (bus.issue && (32'(dest) == i))          busy_d[i] = 1'b1;
         else if (bus.wb_valid && (32'(bus.wb_reg) == i)) busy_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ir_q    <= '0;
         r_in_q  <= '0;
         r_out_q <= '0;
         busy_q  <= '0;
      end else begin
         ir_q    <= ir_d;
         r_in_q  <= r_in_d;
         r_out_q <= r_out_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.r_in    = r_in_q;
   assign bus.r_out   = r_out_q;
   assign bus.busy    = busy_q;
   assign bus.sel_reg = sel_reg;
   assign bus.stall   = stall;

endmodule

// File: tb/tb_reg_select_scoreboard.sv
// Self-checking bench: each driven cycle pushes its expected registered outputs,
// which are popped and compared once the clock edge has produced them.
module tb_reg_select_scoreboard;

   logic clock = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_bad = 0;

   always #5 clock = ~clock;

   reg_select_scoreboard_if #(.NUM_REGS(16), .REG_W(4), .IR_W(32)) bus ();

   reg_select_scoreboard dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       tag;
      logic [15:0] r_in;
      logic [15:0] r_out;
      logic [15:0] busy;
      logic        ba;
   } exp_t;

   exp_t exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_ir(input int opc, input int ra, input int rb, input int rc);
      return (32'(opc) << 27) | (32'(ra) << 23) | (32'(rb) << 19) | (32'(rc) << 15);
   endfunction

   task automatic clear_inputs();
      bus.ir_load   = 1'b0;
      bus.ir_in     = '0;
      bus.gra       = 1'b0;
      bus.grb       = 1'b0;
      bus.grc       = 1'b0;
      bus.r_in_req  = 1'b0;
      bus.r_out_req = 1'b0;
      bus.ba_out    = 1'b0;
      bus.issue     = 1'b0;
      bus.wb_valid  = 1'b0;
      bus.wb_reg    = '0;
   endtask

   // Inputs are already set by the caller; check comb outputs, clock once, check registered ones.
   task automatic cyc(input string tag, input logic e_stall, input logic [3:0] e_sel,
                      input logic [15:0] e_rin, input logic [15:0] e_rout,
                      input logic [15:0] e_busy, input logic e_ba);
      exp_t e;
      e.tag   = tag;
      e.r_in  = e_rin;
      e.r_out = e_rout;
      e.busy  = e_busy;
      e.ba    = e_ba;
      exp_q.push_back(e);
      #1;
      check_eq({tag, ".sel"}, 32'(bus.sel_reg), 32'(e_sel));
      check_eq({tag, ".stall"}, 32'(bus.stall), 32'(e_stall));
      @(posedge clock);
      #1;
      clear_inputs();
      e = exp_q.pop_front();
      check_eq({e.tag, ".r_in"}, 32'(bus.r_in), 32'(e.r_in));
      check_eq({e.tag, ".r_out"}, 32'(bus.r_out), 32'(e.r_out));
      check_eq({e.tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
      check_eq({e.tag, ".ba_zero"}, 32'(bus.ba_zero), 32'(e.ba));
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      @(posedge clock);
      #1;
      // T1 reset, with request inputs active to show they are ignored
      bus.gra = 1'b1; bus.r_in_req = 1'b1; bus.issue = 1'b1;
      cyc("t1_rst0", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      cyc("t1_rst1", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      reset = 1'b0;

      // T2 decode
      bus.ir_load = 1'b1; bus.ir_in = mk_ir(0, 3, 5, 7);
      cyc("t2_load", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      bus.gra = 1'b1; bus.r_in_req = 1'b1;
      cyc("t2_gra_win", 1'b0, 4'd3, 16'h0008, 16'h0, 16'h0, 1'b0);
      bus.grc = 1'b1; bus.r_out_req = 1'b1;
      cyc("t2_grc_rout", 1'b0, 4'd7, 16'h0, 16'h0080, 16'h0, 1'b0);
      bus.gra = 1'b1; bus.grb = 1'b1; bus.grc = 1'b1; bus.r_in_req = 1'b1;
      cyc("t2_prio", 1'b0, 4'd3, 16'h0008, 16'h0, 16'h0, 1'b0);
      bus.grb = 1'b1; bus.grc = 1'b1; bus.r_out_req = 1'b1;
      cyc("t2_prio_b", 1'b0, 4'd5, 16'h0, 16'h0020, 16'h0, 1'b0);
      bus.r_in_req = 1'b1; bus.r_out_req = 1'b1;
      cyc("t2_nosel", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);

      // T3 JAL redirect of Grb to link register
      bus.ir_load = 1'b1; bus.ir_in = mk_ir(20, 1, 2, 3);
      cyc("t3_load", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      bus.grb = 1'b1; bus.r_in_req = 1'b1;
      cyc("t3_jal_grb", 1'b0, 4'd8, 16'h0100, 16'h0, 16'h0, 1'b0);
      bus.gra = 1'b1; bus.r_in_req = 1'b1;
      cyc("t3_jal_gra", 1'b0, 4'd1, 16'h0002, 16'h0, 16'h0, 1'b0);

      // T4 hazard
      bus.ir_load = 1'b1; bus.ir_in = mk_ir(0, 4, 9, 10);
      cyc("t4_load", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      bus.issue = 1'b1;
      cyc("t4_issue", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0010, 1'b0);
      bus.gra = 1'b1; bus.r_out_req = 1'b1;
      cyc("t4_stall", 1'b1, 4'd4, 16'h0, 16'h0, 16'h0010, 1'b0);
      bus.gra = 1'b1; bus.r_in_req = 1'b1;
      cyc("t4_wr_nostall", 1'b0, 4'd4, 16'h0010, 16'h0, 16'h0010, 1'b0);
      bus.wb_valid = 1'b1; bus.wb_reg = 4'd9;
      cyc("t4_wb_idle", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0010, 1'b0);
      bus.gra = 1'b1; bus.r_out_req = 1'b1; bus.wb_valid = 1'b1; bus.wb_reg = 4'd4;
      cyc("t4_wb", 1'b1, 4'd4, 16'h0, 16'h0, 16'h0, 1'b0);
      bus.gra = 1'b1; bus.r_out_req = 1'b1;
      cyc("t4_release", 1'b0, 4'd4, 16'h0, 16'h0010, 16'h0, 1'b0);

      // T5 collision and issue/load ordering
      bus.ir_load = 1'b1; bus.ir_in = mk_ir(0, 6, 0, 0);
      cyc("t5_load", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      bus.issue = 1'b1;
      cyc("t5_issue", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0040, 1'b0);
      bus.issue = 1'b1; bus.wb_valid = 1'b1; bus.wb_reg = 4'd6;
      cyc("t5_collide", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0040, 1'b0);
      bus.wb_valid = 1'b1; bus.wb_reg = 4'd6;
      cyc("t5_retire", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      bus.issue = 1'b1; bus.ir_load = 1'b1; bus.ir_in = mk_ir(0, 2, 0, 0);
      cyc("t5_issue_load", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0040, 1'b0);
      bus.gra = 1'b1; bus.r_out_req = 1'b1;
      cyc("t5_new_ra", 1'b0, 4'd2, 16'h0, 16'h0004, 16'h0040, 1'b0);
      bus.ir_load = 1'b1; bus.ir_in = mk_ir(20, 1, 2, 3);
      cyc("t5_load_jal", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0040, 1'b0);
      bus.issue = 1'b1;
      cyc("t5_issue_jal", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0140, 1'b0);

      // Reset mid-operation drops pending bits and strobes
      reset = 1'b1;
      bus.gra = 1'b1; bus.r_in_req = 1'b1;
      cyc("rst_mid", 1'b0, 4'd1, 16'h0, 16'h0, 16'h0, 1'b0);
      reset = 1'b0;

      // T6 base address
      bus.ir_load = 1'b1; bus.ir_in = mk_ir(0, 1, 0, 5);
      cyc("t6_load", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      bus.grb = 1'b1; bus.ba_out = 1'b1;
`ifdef REG_SEL_BA_ZERO_EN
      cyc("t6_ba_r0", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b1);
`else
      cyc("t6_ba_r0", 1'b0, 4'd0, 16'h0, 16'h0001, 16'h0, 1'b0);
`endif
      bus.grb = 1'b1; bus.r_out_req = 1'b1;
      cyc("t6_rout_r0", 1'b0, 4'd0, 16'h0, 16'h0001, 16'h0, 1'b0);
      bus.issue = 1'b1;
      cyc("t6_issue", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0002, 1'b0);
      bus.gra = 1'b1; bus.ba_out = 1'b1;
      cyc("t6_ba_stall", 1'b1, 4'd1, 16'h0, 16'h0, 16'h0002, 1'b0);
      bus.wb_valid = 1'b1; bus.wb_reg = 4'd1;
      cyc("t6_retire", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
      bus.gra = 1'b1; bus.ba_out = 1'b1;
      cyc("t6_ba_r1", 1'b0, 4'd1, 16'h0, 16'h0002, 16'h0, 1'b0);
      cyc("t6_idle", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
